// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load path; word read over req/ack, stalls until data returns, aligns/extends into MEM_ReadData.
// Optional WAIT timeout abort enabled by defining MEM_LOAD_TIMEOUT_EN.
module mem_load_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic [31:0] MEM_Addr,
  input  logic [2:0]  MEM_LoadType,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MEM_ReadData,
  output logic        ReadData_Valid,
  output logic        Load_Stall,
  output logic        Load_Misalign,
  output logic        Load_Fault
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic [1:0] off;
  logic [2:0] ltype;
  logic misalign, accept, timeout;
  logic [15:0] hw;
  logic [7:0] bt;
  logic [31:0] aligned;
  // Byte loads never misalign; halfwords need an even address; everything else is a word.
  assign misalign = (MEM_LoadType == 3'd1 || MEM_LoadType == 3'd2) ? MEM_Addr[0] :
                    (MEM_LoadType == 3'd3 || MEM_LoadType == 3'd4) ? 1'b0 : |MEM_Addr[1:0];
  assign accept = MEM_MemRead && !misalign;
  assign Load_Stall = (state == IDLE && accept) || state == WAIT;
  assign hw = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign bt = off[0] ? hw[15:8] : hw[7:0];
  assign aligned = ltype == 3'd3 ? {{24{bt[7]}}, bt} :
                   ltype == 3'd4 ? {24'h0, bt} :
                   ltype == 3'd1 ? {{16{hw[15]}}, hw} :
                   ltype == 3'd2 ? {16'h0, hw} : mem_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (accept ? WAIT : IDLE) :
           state == WAIT ? (mem_ack ? DONE : timeout ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req <= 1'b0;
      mem_addr <= '0;
      off <= '0;
      ltype <= '0;
      MEM_ReadData <= '0;
      ReadData_Valid <= 1'b0;
      Load_Misalign <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        mem_addr <= {MEM_Addr[31:2], 2'b00};
        off <= MEM_Addr[1:0];
        ltype <= MEM_LoadType;
      end
      mem_req <= next == WAIT;
      ReadData_Valid <= next == DONE;
      MEM_ReadData <= (state == WAIT && mem_ack) ? aligned : 32'd0;
      Load_Misalign <= state == IDLE && MEM_MemRead && misalign;
    end
`ifdef MEM_LOAD_TIMEOUT_EN
  logic [7:0] cnt;
  // An ack arriving on the limit cycle still completes the read.
  assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1) && !mem_ack;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      Load_Fault <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 8'd1 : 8'd0;
      Load_Fault <= state == WAIT && timeout;
    end
`else
  assign timeout = 1'b0;
  assign Load_Fault = TIMEOUT_CYCLES == 0;
`endif
endmodule
